// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - RV32I opcode constants, encoder formats and opcode-to-format lookup
package instr_encoder_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_BAD} enc_fmt_t;

  function automatic enc_fmt_t fmt_of(input logic [6:0] op);
    case (op)
      OP_IMM, OP_JALR, OP_LOAD: fmt_of = FMT_I;
      OP_STORE:                 fmt_of = FMT_S;
      OP_BRANCH:                fmt_of = FMT_B;
      OP_JAL:                   fmt_of = FMT_J;
      OP_LUI, OP_AUIPC:         fmt_of = FMT_U;
      OP_REG:                   fmt_of = FMT_R;
      default:                  fmt_of = FMT_BAD;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_enc_fifo.sv
// rtl/instr_encoder_enc_fifo.sv - power-of-two output buffer holding {err, instr} entries
module enc_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [32:0] wdata,
  input  logic        pop,
  output logic [32:0] rdata,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [32:0]   mem [DEPTH];
  logic          do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // Head is masked while empty so the outputs read zero during and after reset.
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I field-bundle to instruction encoder with buffered output
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  enc_fmt_t    fmt;
  logic [31:0] enc_instr;
  logic        enc_err;
  logic        accept;
  logic        ready_en;
  logic        full, empty;
  logic [32:0] head;

  assign fmt = fmt_of(in_op);

  always_comb begin
    enc_instr = '0;
    case (fmt)
      FMT_R: enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
      FMT_I: enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
      FMT_S: enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
      FMT_B: enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], in_op};
      FMT_J: enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
      FMT_U: enc_instr = {in_imm[31:12], in_rd, in_op};
      default: enc_instr = NOP_INSTR;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic range_err;

  // Upper bits must replicate the format's sign bit; branch/jump targets must be even.
  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_err = (in_imm[31:11] != {21{in_imm[11]}});
      FMT_B:        range_err = (in_imm[31:12] != {20{in_imm[12]}}) | in_imm[0];
      FMT_J:        range_err = (in_imm[31:20] != {12{in_imm[20]}}) | in_imm[0];
      FMT_U:        range_err = |in_imm[11:0];
      default:      range_err = 1'b0;
    endcase
  end

  assign enc_err = (fmt == FMT_BAD) | range_err;
`else
  assign enc_err = (fmt == FMT_BAD);
`endif

  // ready_en keeps in_ready low through reset and for the edge at which rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en <= 1'b0;
    else     ready_en <= 1'b1;
  end

  assign in_ready = ready_en & ~full;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_count <= '0;
    else if (accept && enc_err && (err_count != '1))
      err_count <= err_count + 1'b1;
  end

  enc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata ({enc_err, enc_instr}),
    .pop   (out_ready),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = ~empty;
  assign out_err   = head[32];
  assign out_instr = head[31:0];

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, output buffer entries; power of two, >= 2.
REQ-002 SHALL provide parameter CNT_W, default 16, width of the error counter.
REQ-003 SHALL provide port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port in_valid  input  1  field bundle valid.
REQ-006 SHALL provide port in_ready  output  1  bundle accepted when in_valid and in_ready are both high.
REQ-007 SHALL provide port in_op  input  7  RV32I opcode.
REQ-008 SHALL provide ports in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-009 SHALL provide ports in_funct3  input  3 and in_funct7  input  7  function fields.
REQ-010 SHALL provide port in_imm  input  32  immediate as sign-extended value (U-type: final upper value, low 12 bits zero).
REQ-011 SHALL provide port out_valid  output  1  buffered instruction available.
REQ-012 SHALL provide port out_ready  input  1  consumer pops head when out_valid and out_ready are both high.
REQ-013 SHALL provide port out_instr  output  32  encoded instruction at head.
REQ-014 SHALL provide port out_err  output  1  head entry failed an encode check.
REQ-015 SHALL provide port err_count  output  CNT_W  saturating count of accepted bundles flagged in error.

Function
REQ-016 Format SHALL be selected from in_op:
- I: OP_IMM, OP_JALR, OP_LOAD
- S: OP_STORE
- B: OP_BRANCH
- J: OP_JAL
- U: OP_LUI, OP_AUIPC
- R: OP_REG
REQ-017 Immediate bit placement SHALL be the exact RV32I inverse: I imm[11:0]->[31:20]; S imm[11:5]->[31:25], imm[4:0]->[11:7]; B imm[12|10:5]->[31|30:25], imm[4:1|11]->[11:8|7]; J imm[20|10:1|11|19:12]->[31|30:21|20|19:12]; U imm[31:12]->[31:12].
REQ-018 Encoding SHALL insert only fields the format defines: rd for R/I/U/J; rs1 for R/I/S/B; rs2 for R/S/B; funct3 for R/I/S/B; funct7 for R. Unused fields SHALL be zero.
REQ-019 An unrecognised opcode SHALL encode to 32'h0000_0013 (NOP) with error set.
REQ-020 An accepted bundle SHALL be written into the buffer at the accepting edge; out_valid SHALL rise on the next cycle (latency 1).
REQ-021 in_ready SHALL equal not-full; there is no bypass when full, even if out_ready is high.
REQ-022 out_valid SHALL equal not-empty. out_instr and out_err SHALL reflect the head entry and hold stable while out_valid is high and out_ready is low.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged. On empty, only the push takes effect. Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 err_count SHALL increment on each accepted bundle with error and SHALL saturate at all-ones.

Reset
REQ-025 While rst is high, the block SHALL immediately (asynchronously) drive:
- buffer empty; both pointers zero
- out_valid=0, out_err=0, out_instr=0
- err_count=0
- in_ready=0
REQ-026 A bundle presented mid-reset SHALL be dropped. In-flight buffer contents SHALL be discarded. in_ready SHALL rise on the first clock edge after rst falls.

Configuration
REQ-027 With ENC_RANGE_CHECK_EN defined, the error flag SHALL also be set when the immediate is out of range:
- I/S: in_imm outside signed 12-bit
- B: outside signed 13-bit, or in_imm[0]=1
- J: outside signed 21-bit, or in_imm[0]=1
- U: in_imm[11:0] nonzero
Flagged entries SHALL still be encoded from the truncated bits.
REQ-028 Without ENC_RANGE_CHECK_EN, only REQ-019 SHALL set the error flag, and no range logic SHALL be synthesised.

Structure
REQ-029 Opcode constants SHALL live in the shared types package, including OP_REG, alongside the existing OP_* constants. The shared types package SHALL also hold a new enum enc_fmt_t {FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_BAD}.
REQ-030 Buffering SHALL be a sub-module enc_fifo (parameter DEPTH, 33-bit data = {err, instr}). Encoding and checking SHALL stay in instr_encoder.

Verification
REQ-031 addi x1,x0,-1 (OP_IMM, rd=1, f3=0, imm=32'hFFFF_FFFF) -> out_instr=32'hFFF0_0093, out_err=0, out_valid one cycle after accept.
REQ-032 beq x1,x2,-4 (imm=32'hFFFF_FFFC) -> out_instr=32'hFE20_8EE3. jal x1,+2048 -> out_instr=32'h0010_00EF.
REQ-033 With macro: OP_IMM imm=2048 -> out_err=1, err_count=1. OP_BRANCH imm=3 -> out_err=1. Same stimulus without macro -> out_err=0.
REQ-034 in_op=7'h7F -> out_instr=32'h0000_0013, out_err=1. err_count preset near max then saturates at 16'hFFFF.
REQ-035 out_ready=0, push DEPTH+1 bundles -> in_ready low after DEPTH accepts. Enable out_ready -> DEPTH entries drained in order. Concurrent push/pop keeps count.
REQ-036 Assert rst with 3 entries buffered -> out_valid=0 immediately. After release, first new bundle is output first.
